// File: rtl/mdu_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_issue_ctrl_pkg
// Brief    : Shared constants, state encodings and result select for the
//            M-extension issue controller.
// Revision : 1.0
// ============================================================================
package mdu_issue_ctrl_pkg;

    localparam logic [2:0] c_FUNCT3_MUL = 3'b000;

    // Signed-division overflow operands (INT_MIN / -1)
    localparam logic [31:0] c_MDU_DIV_OVF_A = 32'h8000_0000;
    localparam logic [31:0] c_MDU_DIV_OVF_B = 32'hFFFF_FFFF;

    localparam int unsigned c_STATE_W = 3;
    localparam logic [c_STATE_W-1:0] c_S_IDLE  = 3'd0;
    localparam logic [c_STATE_W-1:0] c_S_ISSUE = 3'd1;
    localparam logic [c_STATE_W-1:0] c_S_WAIT  = 3'd2;
    localparam logic [c_STATE_W-1:0] c_S_RESP  = 3'd3;
    localparam logic [c_STATE_W-1:0] c_S_DRAIN = 3'd4;

    function automatic logic is_mul_op(input logic [2:0] funct3);
        return !funct3[2];
    endfunction

    // MUL takes the low product word, the MULH family the high word;
    // funct3[1] separates REM/REMU from DIV/DIVU.
    function automatic logic [31:0] select_result(
        input logic [2:0]  funct3,
        input logic [63:0] product,
        input logic [31:0] quotient,
        input logic [31:0] remainder
    );
        logic [31:0] v;
        if (!funct3[2]) begin
            v = (funct3 == c_FUNCT3_MUL) ? product[31:0] : product[63:32];
        end else begin
            v = funct3[1] ? remainder : quotient;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_issue_ctrl_cache.sv
`default_nettype none
// ============================================================================
// Module   : mdu_issue_ctrl_cache
// Brief    : Last-result store for the mdu with fused-pair hit detection
//            and result word selection.
// Revision : 1.0
// ============================================================================
module mdu_issue_ctrl_cache
    import mdu_issue_ctrl_pkg::*;
#(
    parameter int EN_CACHE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  i_lk_funct3,
    input  logic [31:0] i_lk_rs1,
    input  logic [31:0] i_lk_rs2,
    output logic        o_hit,
    output logic [31:0] o_hit_data,
    input  logic        i_upd,
    input  logic [2:0]  i_upd_funct3,
    input  logic [31:0] i_upd_rs1,
    input  logic [31:0] i_upd_rs2,
    input  logic [63:0] i_product,
    input  logic [31:0] i_quotient,
    input  logic [31:0] i_remainder,
    output logic [31:0] o_done_data
);

    localparam logic c_EN = (EN_CACHE != 0);

    logic        r_valid;
    logic [2:0]  r_funct3;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic [63:0] r_product;
    logic [31:0] r_quotient;
    logic [31:0] r_remainder;

    logic w_same_ops;
    logic w_div_hit;
    logic w_mul_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_funct3    <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_product   <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else if (i_upd) begin
            r_valid     <= 1'b1;
            r_funct3    <= i_upd_funct3;
            r_rs1       <= i_upd_rs1;
            r_rs2       <= i_upd_rs2;
            r_product   <= i_product;
            r_quotient  <= i_quotient;
            r_remainder <= i_remainder;
        end
    end

    assign w_same_ops = r_valid && (r_rs1 == i_lk_rs1) && (r_rs2 == i_lk_rs2);

    // Divides share quotient and remainder only when signedness matches.
    assign w_div_hit = !is_mul_op(i_lk_funct3) && !is_mul_op(r_funct3)
                       && (i_lk_funct3[0] == r_funct3[0]);

    // Low product word is signedness-independent, so MUL reuses any multiply.
    assign w_mul_hit = is_mul_op(i_lk_funct3) && is_mul_op(r_funct3)
                       && ((i_lk_funct3 == r_funct3) || (i_lk_funct3 == c_FUNCT3_MUL));

    assign o_hit       = c_EN && w_same_ops && (w_div_hit || w_mul_hit);
    assign o_hit_data  = select_result(i_lk_funct3, r_product, r_quotient, r_remainder);
    assign o_done_data = select_result(i_upd_funct3, i_product, i_quotient, i_remainder);

endmodule
`default_nettype wire

// File: rtl/mdu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mdu_issue_ctrl
// Brief    : Issues M-extension ops to the iterative mdu, resolves special
//            cases locally and returns results on a writeback handshake.
// Revision : 1.0
// ============================================================================
module mdu_issue_ctrl
    import mdu_issue_ctrl_pkg::*;
#(
    parameter int EN_FASTPATH = 1,
    parameter int EN_CACHE    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic        mdu_start,
    output logic [2:0]  mdu_funct3,
    output logic [31:0] mdu_a,
    output logic [31:0] mdu_b,
    input  logic        mdu_busy,
    input  logic        mdu_done,
    input  logic [63:0] mdu_product,
    input  logic [31:0] mdu_quotient,
    input  logic [31:0] mdu_remainder,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        stall
);

    localparam logic c_FAST_EN = (EN_FASTPATH != 0);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_nxt;

    logic [2:0]  r_funct3;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic [4:0]  r_rd;
    logic [31:0] r_wb_data;

    logic        w_accept;
    logic        w_start;
    logic        w_capture;
    logic        w_fast_cond;
    logic        w_fast_hit;
    logic [31:0] w_fast_data;
    logic        w_cache_hit;
    logic [31:0] w_cache_data;
    logic [31:0] w_done_data;

    mdu_issue_ctrl_cache #(
        .EN_CACHE (EN_CACHE)
    ) u_cache (
        .clk          (clk),
        .rst          (rst),
        .i_lk_funct3  (req_funct3),
        .i_lk_rs1     (req_rs1),
        .i_lk_rs2     (req_rs2),
        .o_hit        (w_cache_hit),
        .o_hit_data   (w_cache_data),
        .i_upd        (w_capture),
        .i_upd_funct3 (r_funct3),
        .i_upd_rs1    (r_rs1),
        .i_upd_rs2    (r_rs2),
        .i_product    (mdu_product),
        .i_quotient   (mdu_quotient),
        .i_remainder  (mdu_remainder),
        .o_done_data  (w_done_data)
    );

    // Special cases resolved from the raw request operands.
    always_comb begin
        w_fast_cond = 1'b0;
        w_fast_data = '0;
        if (is_mul_op(req_funct3)) begin
            w_fast_cond = (req_rs1 == '0) || (req_rs2 == '0);
        end else if (req_rs2 == '0) begin
            w_fast_cond = 1'b1;
            w_fast_data = req_funct3[1] ? req_rs1 : 32'hFFFF_FFFF;
        end else if (!req_funct3[0] && (req_rs1 == c_MDU_DIV_OVF_A)
                     && (req_rs2 == c_MDU_DIV_OVF_B)) begin
            w_fast_cond = 1'b1;
            w_fast_data = req_funct3[1] ? 32'h0000_0000 : c_MDU_DIV_OVF_A;
        end
    end

    assign w_fast_hit = c_FAST_EN && w_fast_cond;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_start     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (req_valid && !flush) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (w_fast_hit || w_cache_hit) ? c_S_RESP : c_S_ISSUE;
                end
            end
            c_S_ISSUE: begin
                if (flush) begin
                    w_state_nxt = c_S_IDLE;
                end else if (!mdu_busy) begin
                    w_start     = 1'b1;
                    w_state_nxt = c_S_WAIT;
                end
            end
            c_S_WAIT: begin
                // A done coinciding with flush is dropped just like a drained one.
                if (mdu_done) begin
                    if (flush) begin
                        w_state_nxt = c_S_IDLE;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = c_S_RESP;
                    end
                end else if (flush) begin
                    w_state_nxt = c_S_DRAIN;
                end
            end
            c_S_RESP: begin
                if (flush || wb_ready) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            c_S_DRAIN: begin
                if (mdu_done) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_funct3  <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_wb_data <= '0;
        end else if (w_accept) begin
            r_funct3 <= req_funct3;
            r_rs1    <= req_rs1;
            r_rs2    <= req_rs2;
            r_rd     <= req_rd;
            if (w_fast_hit) begin
                r_wb_data <= w_fast_data;
            end else if (w_cache_hit) begin
                r_wb_data <= w_cache_data;
            end
        end else if (w_capture) begin
            r_wb_data <= w_done_data;
        end
    end

    // rst gates req_ready so every output is low while reset is held.
    assign req_ready  = !rst && (r_state == c_S_IDLE) && !flush;
    assign mdu_start  = w_start;
    assign mdu_funct3 = r_funct3;
    assign mdu_a      = r_rs1;
    assign mdu_b      = r_rs2;
    assign wb_valid   = (r_state == c_S_RESP);
    assign wb_rd      = r_rd;
    assign wb_data    = r_wb_data;
    assign stall      = (r_state != c_S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mdu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_issue_ctrl
// Brief    : Directed plus randomized bench for mdu_issue_ctrl with an
//            iterative-mdu model and a RISC-V M-extension reference.
// Revision : 1.0
// ============================================================================
module tb_mdu_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [4:0]  req_rd;
    logic        flush;
    logic        mdu_start;
    logic [2:0]  mdu_funct3;
    logic [31:0] mdu_a;
    logic [31:0] mdu_b;
    logic        mdu_busy;
    logic        mdu_done;
    logic [63:0] mdu_product;
    logic [31:0] mdu_quotient;
    logic [31:0] mdu_remainder;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    // mdu model state
    logic        m_busy;
    int          m_cnt;
    logic [2:0]  m_f3;
    logic [31:0] m_a;
    logic [31:0] m_b;
    int          lat_cfg = 3;
    logic        force_busy = 1'b0;
    int          start_cnt = 0;
    int          viol_cnt  = 0;
    logic [2:0]  cap_f3;
    logic [31:0] cap_a;
    logic [31:0] cap_b;

    // reference record of the last op the mdu completed for the controller
    logic        last_v = 1'b0;
    logic [2:0]  last_f3;
    logic [31:0] last_a;
    logic [31:0] last_b;

    mdu_issue_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_funct3    (req_funct3),
        .req_rs1       (req_rs1),
        .req_rs2       (req_rs2),
        .req_rd        (req_rd),
        .flush         (flush),
        .mdu_start     (mdu_start),
        .mdu_funct3    (mdu_funct3),
        .mdu_a         (mdu_a),
        .mdu_b         (mdu_b),
        .mdu_busy      (mdu_busy),
        .mdu_done      (mdu_done),
        .mdu_product   (mdu_product),
        .mdu_quotient  (mdu_quotient),
        .mdu_remainder (mdu_remainder),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .stall         (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] prod64(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] xa;
        logic [63:0] xb;
        xa = (f3 == 3'b011) ? {32'h0, a} : {{32{a[31]}}, a};
        xb = (f3 == 3'b010 || f3 == 3'b011) ? {32'h0, b} : {{32{b[31]}}, b};
        return xa * xb;
    endfunction

    function automatic logic [31:0] rv_m(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
        logic [63:0] p;
        logic        ovf;
        p   = prod64(f3, a, b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'b000:                 return a * b;
            3'b001, 3'b010, 3'b011: return p[63:32];
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return 32'($signed(a) / $signed(b));
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return 32'($signed(a) % $signed(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Predicts whether an accepted request must go to the mdu.
    function automatic logic predict_issue(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        logic is_mul;
        logic same;
        is_mul = (f3 < 3'd4);
        if (is_mul && (a == 0 || b == 0)) return 1'b0;
        if (!is_mul && b == 0) return 1'b0;
        if ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 1'b0;
        same = last_v && (last_a == a) && (last_b == b);
        if (same && !is_mul && last_f3 >= 3'd4 && (f3[0] == last_f3[0])) return 1'b0;
        if (same && is_mul && last_f3 < 3'd4 && (f3 == last_f3 || f3 == 3'b000)) return 1'b0;
        return 1'b1;
    endfunction

    assign mdu_busy = m_busy | force_busy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy        <= 1'b0;
            m_cnt         <= 0;
            m_f3          <= '0;
            m_a           <= '0;
            m_b           <= '0;
            mdu_done      <= 1'b0;
            mdu_product   <= '0;
            mdu_quotient  <= '0;
            mdu_remainder <= '0;
        end else begin
            mdu_done <= 1'b0;
            if (mdu_start) begin
                m_busy <= 1'b1;
                m_cnt  <= lat_cfg;
                m_f3   <= mdu_funct3;
                m_a    <= mdu_a;
                m_b    <= mdu_b;
            end else if (m_busy) begin
                if (m_cnt <= 1) begin
                    m_busy        <= 1'b0;
                    mdu_done      <= 1'b1;
                    mdu_product   <= prod64(m_f3, m_a, m_b);
                    mdu_quotient  <= rv_m({2'b10, m_f3[0]}, m_a, m_b);
                    mdu_remainder <= rv_m({2'b11, m_f3[0]}, m_a, m_b);
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (mdu_start) begin
            start_cnt <= start_cnt + 1;
            cap_f3    <= mdu_funct3;
            cap_a     <= mdu_a;
            cap_b     <= mdu_b;
            if (mdu_busy) viol_cnt <= viol_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int hold);
        logic [31:0] exp_data;
        logic        exp_issue;
        int          s0;
        int          n;
        exp_data  = rv_m(f3, a, b);
        exp_issue = predict_issue(f3, a, b);
        s0        = start_cnt;
        check("req_ready_idle", req_ready, 32'd1);
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_rs1    = a;
        req_rs2    = b;
        req_rd     = rd;
        @(negedge clk);
        req_valid = 1'b0;
        check("stall_after_accept", stall, 32'd1);
        if (!exp_issue) check("wb_valid_next_cycle", wb_valid, 32'd1);
        for (n = 0; n < 200 && !wb_valid; n++) @(negedge clk);
        check("wb_valid_seen", wb_valid, 32'd1);
        for (int i = 0; i < hold; i++) begin
            check("hold_wb_valid", wb_valid, 32'd1);
            check("hold_wb_rd", wb_rd, 32'(rd));
            check("hold_wb_data", wb_data, exp_data);
            @(negedge clk);
        end
        check("wb_data", wb_data, exp_data);
        check("wb_rd", wb_rd, 32'(rd));
        check("start_count", 32'(start_cnt - s0), 32'(exp_issue));
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
        check("wb_valid_dropped", wb_valid, 32'd0);
        check("stall_idle", stall, 32'd0);
        if (exp_issue) begin
            last_v  = 1'b1;
            last_f3 = f3;
            last_a  = a;
            last_b  = b;
        end
    endtask

    // Accepts a request that must go to the mdu and returns once start is seen.
    task automatic issue_until_start(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
        int s0;
        int n;
        s0         = start_cnt;
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_rs1    = a;
        req_rs2    = b;
        req_rd     = 5'd9;
        @(negedge clk);
        req_valid = 1'b0;
        for (n = 0; n < 50 && start_cnt == s0; n++) @(negedge clk);
        check("start_seen", 32'(start_cnt - s0), 32'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          n;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_funct3 = '0;
        req_rs1    = '0;
        req_rs2    = '0;
        req_rd     = '0;
        flush      = 1'b0;
        wb_ready   = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 32'd0);
        check("rst_wb_valid", wb_valid, 32'd0);
        check("rst_stall", stall, 32'd0);
        check("rst_mdu_start", mdu_start, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // DIV then fused REM on identical operands
        do_op(3'b100, 32'd100, 32'd7, 5'd5, 0);
        check("issue_a", cap_a, 32'd100);
        check("issue_b", cap_b, 32'd7);
        check("issue_f3", 32'(cap_f3), 32'd4);
        do_op(3'b110, 32'd100, 32'd7, 5'd6, 0);

        // divide-by-zero and overflow special cases
        do_op(3'b101, 32'h1234, 32'h0, 5'd7, 0);
        do_op(3'b110, 32'hFFFF_FFF0, 32'h0, 5'd8, 0);
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0);
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
        do_op(3'b000, 32'h0, 32'h1234_5678, 5'd12, 0);

        // MULHU through the mdu, then MUL from the cached product
        do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 0);
        do_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 0);

        // writeback backpressure
        do_op(3'b001, 32'h0001_2345, 32'hFEDC_BA98, 5'd17, 3);

        // mdu busy from elsewhere holds the start back
        force_busy = 1'b1;
        fork
            do_op(3'b010, 32'hFFFF_FFF3, 32'd1000, 5'd18, 0);
            begin
                repeat (4) @(negedge clk);
                force_busy = 1'b0;
            end
        join

        // flush in WAIT drains the mdu and leaves the cache untouched
        lat_cfg = 15;
        issue_until_start(3'b101, 32'd9, 32'd3);
        repeat (5) @(negedge clk);
        flush = 1'b1;
        check("flush_req_ready", req_ready, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        for (n = 0; n < 60 && !mdu_done; n++) begin
            check("drain_wb_valid", wb_valid, 32'd0);
            check("drain_req_ready", req_ready, 32'd0);
            @(negedge clk);
        end
        check("drain_done_seen", mdu_done, 32'd1);
        check("drain_wb_valid_at_done", wb_valid, 32'd0);
        @(negedge clk);
        check("drain_back_idle", req_ready, 32'd1);
        lat_cfg = 3;
        do_op(3'b101, 32'd9, 32'd3, 5'd19, 0);

        // asynchronous reset mid-WAIT
        lat_cfg = 20;
        issue_until_start(3'b001, 32'h7777_0001, 32'h0000_0003);
        repeat (2) @(negedge clk);
        check("wait_stall", stall, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_stall", stall, 32'd0);
        check("async_rst_wb_valid", wb_valid, 32'd0);
        check("async_rst_mdu_start", mdu_start, 32'd0);
        check("async_rst_req_ready", req_ready, 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        last_v = 1'b0;
        lat_cfg = 3;
        @(negedge clk);
        do_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20, 0);

        // randomized traffic
        ra = 32'd5;
        rb = 32'd3;
        for (int k = 0; k < 60; k++) begin
            lat_cfg = $urandom_range(1, 6);
            if ($urandom_range(0, 2) != 0) begin
                ra = pick();
                rb = pick();
            end
            do_op(3'($urandom_range(0, 7)), ra, rb, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 2));
        end

        check("no_start_while_busy", 32'(viol_cnt), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
Sits between the execute stage and the iterative multiply/divide unit (`mdu`); owns all M-extension instructions.
- Accepts one request from execute and issues a start pulse to `mdu`.
- Waits for `mdu` to finish, selects the 32-bit result and presents it on a writeback handshake.
- Resolves RISC-V special cases (divide-by-zero, signed overflow, multiply-by-zero) without invoking `mdu`.
- Reuses the last `mdu` result for fused pairs (DIV/REM, MULH/MUL) on identical operands.

Parameters:
EN_FASTPATH, 1, enable special-case bypass (0: all ops go to mdu)
EN_CACHE, 1, enable last-result reuse (0: cache never hits)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  M-op request from execute
req_ready  out  1  block can accept request
req_funct3  in  3  RISC-V M funct3 (MUL=000 MULH=001 MULHSU=010 MULHU=011 DIV=100 DIVU=101 REM=110 REMU=111)
req_rs1  in  32  operand a
req_rs2  in  32  operand b
req_rd  in  5  destination register
flush  in  1  kill in-flight op (pipeline redirect)
mdu_start  out  1  one-cycle start pulse to mdu
mdu_funct3  out  3  registered op to mdu
mdu_a  out  32  registered operand a
mdu_b  out  32  registered operand b
mdu_busy  in  1  mdu busy
mdu_done  in  1  mdu one-cycle done pulse
mdu_product  in  64  mdu product
mdu_quotient  in  32  mdu quotient
mdu_remainder  in  32  mdu remainder
wb_valid  out  1  result valid
wb_ready  in  1  writeback accepts result
wb_rd  out  5  destination register
wb_data  out  32  result
stall  out  1  high whenever state != IDLE

Behaviour:
- Clock is `clk`; reset is `rst`, asynchronous, active-high. On `rst`, all outputs go to 0 immediately, the state goes to IDLE and the cache valid bit clears. The mdu is reset separately.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE:
  - `req_ready` = !flush.
  - Accept when `req_valid && req_ready`; latch funct3, rs1, rs2 and rd.
  - Fast-path or cache hit: load `wb_data` and go to RESP. `wb_valid` rises the cycle after accept.
  - Otherwise: go to ISSUE.
- ISSUE:
  - `mdu_a`, `mdu_b` and `mdu_funct3` hold the latched values.
  - If `!mdu_busy`, drive `mdu_start`=1 for exactly that cycle and go to WAIT; otherwise stay in ISSUE with start=0.
- WAIT:
  - On `mdu_done`, capture the selected result into `wb_data`, update the cache and go to RESP.
  - Result select: MUL → product[31:0]; MULH/MULHSU/MULHU → product[63:32]; DIV/DIVU → quotient; REM/REMU → remainder.
- RESP:
  - `wb_valid`=1; `wb_rd` and `wb_data` are held stable until `wb_ready`.
  - On `wb_ready`, drop `wb_valid` and go to IDLE. A new request can be accepted the following cycle.
- flush:
  - In ISSUE before start was sent: go to IDLE.
  - After start was sent (WAIT): go to DRAIN.
  - In RESP: drop `wb_valid` and go to IDLE; the cache keeps its value.
  - In IDLE: blocks acceptance that cycle.
- DRAIN: wait for `mdu_done`, discard the result (no cache update, no `wb_valid`), then go to IDLE.
- Fast path (EN_FASTPATH=1), evaluated in IDLE on raw request operands:
  - rs2==0 with DIV/DIVU → 0xFFFFFFFF.
  - rs2==0 with REM/REMU → rs1 (original, unsigned/unnegated).
  - DIV with rs1=0x80000000 and rs2=0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
  - Any mul op with rs1==0 or rs2==0 → 0.
  - Fast path has priority over the cache.
- Cache (EN_CACHE=1):
  - Holds valid, rs1, rs2, funct3, product[63:0], quotient and remainder of the last mdu-completed op.
  - Div hit: both ops are div-class, rs1 and rs2 equal, and funct3[0] equal (same signedness).
  - Mul hit: both ops are mul-class, rs1 and rs2 equal, and either funct3 equal or request funct3==MUL.
- Simultaneous `mdu_done` and flush in WAIT: the result is discarded, the cache is not updated, and the state goes to IDLE.

Decomposition:
- `riscv_defines.vh` gains:
  - the state encodings;
  - `MDU_DIV_OVF_A` = 0x80000000;
  - `MDU_DIV_OVF_B` = 0xFFFFFFFF.
- Existing `FUNCT3_*` macros are reused.
- Natural sub-module: `mdu_result_cache`, holding the storage, hit compare and result select; the FSM and fast path stay in the top.

Test Plan:
- DIV rs1=100 rs2=7 with cold cache → `mdu_start` pulses once (a=100, b=7, funct3=100), then `wb_data`=14. Follow with REM 100,7 → no `mdu_start`; `wb_data`=2 and `wb_valid` the cycle after accept.
- DIVU 0x1234/0 → 0xFFFFFFFF; REM 0xFFFFFFF0/0 → 0xFFFFFFF0. Neither issues `mdu_start`.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM with the same operands → 0. Neither issues `mdu_start`.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE via mdu. Then MUL with the same operands → 0x00000001 from cache, no start.
- Flush asserted 5 cycles into WAIT → DRAIN. `wb_valid` never rises and `req_ready` stays 0 until `mdu_done`. A following DIVU 9/3 issues `mdu_start` (no cache hit) and returns 3.
- `wb_ready` held low 3 cycles → `wb_valid`, `wb_rd` and `wb_data` stay stable. Separately, `rst` raised mid-WAIT → `stall`, `wb_valid` and `mdu_start` drop to 0 without waiting for a clock edge.
